// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared types and constants for the RT end-of-computation monitor
package rt_pkg;

    typedef enum logic [1:0] {
        EOC_IDLE    = 2'd0,
        EOC_ARMED   = 2'd1,
        EOC_DONE    = 2'd2,
        EOC_TIMEOUT = 2'd3
    } eoc_state_e;

    localparam int EocCodeW          = 31;
    localparam int EocTimeoutDefault = 1000000;

endpackage

// File: rtl/rt_eoc_channel.sv
// rtl/rt_eoc_channel.sv - per-channel exit-code handshake, fail flag and heartbeat edge tracker
// Ports: clk_i/rst_i clock and sync active-high reset; arm_i re-arm strobe; armed_i FSM is ARMED;
//        en_i channel enable (used on arm); valid_i/code_i exit code; heartbeat_i activity pin;
//        ready_o handshake ready; accept_o handshake this cycle; code_nz_o accepted code nonzero;
//        seen_o/fail_o/hb_seen_o registered channel status.
module rt_eoc_channel
    import rt_pkg::*;
#(
    parameter int CodeW = EocCodeW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             arm_i,
    input  logic             armed_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [CodeW-1:0] code_i,
    input  logic             heartbeat_i,
    output logic             ready_o,
    output logic             accept_o,
    output logic             code_nz_o,
    output logic             seen_o,
    output logic             fail_o,
    output logic             hb_seen_o
);

    logic r_seen;
    logic r_fail;
    logic r_hb_seen;
    logic r_hb_prev;

    // Once a code is taken, ready stays low so repeated valids are silently ignored.
    assign ready_o   = armed_i & ~r_seen;
    assign accept_o  = valid_i & ready_o;
    assign code_nz_o = |code_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_seen    <= 1'b0;
            r_fail    <= 1'b0;
            r_hb_seen <= 1'b0;
            r_hb_prev <= 1'b0;
        end else if (arm_i) begin
            // Disabled channels count as already reported; capturing the current
            // pin level means a pin that is already high is not an edge.
            r_seen    <= ~en_i;
            r_fail    <= 1'b0;
            r_hb_seen <= 1'b0;
            r_hb_prev <= heartbeat_i;
        end else begin
            r_hb_prev <= heartbeat_i;
            if (accept_o) begin
                r_seen <= 1'b1;
                r_fail <= code_nz_o;
            end
            if (armed_i && heartbeat_i && !r_hb_prev) begin
                r_hb_seen <= 1'b1;
            end
        end
    end

    assign seen_o    = r_seen;
    assign fail_o    = r_fail;
    assign hb_seen_o = r_hb_seen;

endmodule

// File: rtl/rt_eoc_monitor.sv
// rtl/rt_eoc_monitor.sv - N-channel end-of-computation collector with watchdog and first-fail capture
// Ports: clk_i/rst_i clock and sync active-high reset; start_i arm pulse; ch_en_i enables;
//        eoc_valid_i/eoc_code_i/eoc_ready_o per-channel exit-code handshake; heartbeat_i activity pins;
//        state_o/done_o/pass_o/timeout_o aggregate status; seen/fail/hb_seen masks; first-fail index/code.
module rt_eoc_monitor
    import rt_pkg::*;
#(
    parameter int NumCh         = 4,
    parameter int CodeW         = EocCodeW,
    parameter int TimeoutCycles = EocTimeoutDefault
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [NumCh-1:0]       ch_en_i,
    input  logic [NumCh-1:0]       eoc_valid_i,
    input  logic [NumCh*CodeW-1:0] eoc_code_i,
    output logic [NumCh-1:0]       eoc_ready_o,
    input  logic [NumCh-1:0]       heartbeat_i,
    output logic [1:0]             state_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic                   timeout_o,
    output logic [NumCh-1:0]       seen_mask_o,
    output logic [NumCh-1:0]       fail_mask_o,
    output logic [NumCh-1:0]       hb_seen_o,
    output logic [((NumCh > 1) ? $clog2(NumCh) : 1)-1:0] first_fail_idx_o,
    output logic [CodeW-1:0]       first_fail_code_o
);

    localparam int IdxW = (NumCh > 1) ? $clog2(NumCh) : 1;
    localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    eoc_state_e       r_state;
    eoc_state_e       w_state_next;
    logic [CntW-1:0]  r_cnt;
    logic             r_ff_valid;
    logic [IdxW-1:0]  r_ff_idx;
    logic [CodeW-1:0] r_ff_code;

    logic             w_armed;
    logic [NumCh-1:0] w_accept;
    logic [NumCh-1:0] w_code_nz;
    logic [NumCh-1:0] w_seen;
    logic [NumCh-1:0] w_fail;
    logic [NumCh-1:0] w_fail_acc;
    logic             w_all_seen;
    logic             w_expire;
    logic             w_ff_hit;
    logic [IdxW-1:0]  w_ff_idx;
    logic [CodeW-1:0] w_ff_code;

    assign w_armed = (r_state == EOC_ARMED);

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        rt_eoc_channel #(.CodeW(CodeW)) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .arm_i       (start_i),
            .armed_i     (w_armed),
            .en_i        (ch_en_i[c]),
            .valid_i     (eoc_valid_i[c]),
            .code_i      (eoc_code_i[c*CodeW +: CodeW]),
            .heartbeat_i (heartbeat_i[c]),
            .ready_o     (eoc_ready_o[c]),
            .accept_o    (w_accept[c]),
            .code_nz_o   (w_code_nz[c]),
            .seen_o      (w_seen[c]),
            .fail_o      (w_fail[c]),
            .hb_seen_o   (hb_seen_o[c])
        );
    end

    // Completion includes this cycle's accepts so DONE follows the final handshake directly.
    assign w_all_seen = &(w_seen | w_accept);
    assign w_expire   = (TimeoutCycles != 0) && (r_cnt == CntW'(TimeoutCycles - 1));
    assign w_fail_acc = w_accept & w_code_nz;

    // Scan downwards so the lowest failing index among simultaneous accepts wins.
    always_comb begin
        w_ff_hit  = 1'b0;
        w_ff_idx  = '0;
        w_ff_code = '0;
        for (int c = NumCh - 1; c >= 0; c--) begin
            if (w_fail_acc[c]) begin
                w_ff_hit  = 1'b1;
                w_ff_idx  = IdxW'(c);
                w_ff_code = eoc_code_i[c*CodeW +: CodeW];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= EOC_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start_i) begin
            w_state_next = EOC_ARMED;
        end else if (r_state == EOC_ARMED) begin
            if (w_all_seen) begin
                w_state_next = EOC_DONE;
            end else if (w_expire) begin
                w_state_next = EOC_TIMEOUT;
            end
        end
    end

    always_comb begin
        state_o   = r_state;
        done_o    = (r_state == EOC_DONE);
        timeout_o = (r_state == EOC_TIMEOUT);
        pass_o    = (r_state == EOC_DONE) && !(|w_fail);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            r_cnt <= '0;
        end else if (w_armed && (r_cnt != CntW'(TimeoutCycles))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            r_ff_valid <= 1'b0;
            r_ff_idx   <= '0;
            r_ff_code  <= '0;
        end else if (w_armed && !r_ff_valid && w_ff_hit) begin
            r_ff_valid <= 1'b1;
            r_ff_idx   <= w_ff_idx;
            r_ff_code  <= w_ff_code;
        end
    end

    assign seen_mask_o       = w_seen;
    assign fail_mask_o       = w_fail;
    assign first_fail_idx_o  = r_ff_idx;
    assign first_fail_code_o = r_ff_code;

endmodule

// File: tb/tb_rt_eoc_monitor.sv
// tb/tb_rt_eoc_monitor.sv - directed self-checking bench for rt_eoc_monitor
module tb_rt_eoc_monitor;

    localparam int NumCh = 4;
    localparam int CodeW = 31;
    localparam int Tmo   = 100;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic [NumCh-1:0]       ch_en = '0;
    logic [NumCh-1:0]       valid = '0;
    logic [NumCh*CodeW-1:0] code = '0;
    logic [NumCh-1:0]       ready;
    logic [NumCh-1:0]       heartbeat = '0;
    logic [1:0]             state;
    logic                   done;
    logic                   pass;
    logic                   timeout;
    logic [NumCh-1:0]       seen;
    logic [NumCh-1:0]       fail;
    logic [NumCh-1:0]       hb_seen;
    logic [1:0]             ff_idx;
    logic [CodeW-1:0]       ff_code;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rt_eoc_monitor #(.NumCh(NumCh), .CodeW(CodeW), .TimeoutCycles(Tmo)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .ch_en_i           (ch_en),
        .eoc_valid_i       (valid),
        .eoc_code_i        (code),
        .eoc_ready_o       (ready),
        .heartbeat_i       (heartbeat),
        .state_o           (state),
        .done_o            (done),
        .pass_o            (pass),
        .timeout_o         (timeout),
        .seen_mask_o       (seen),
        .fail_mask_o       (fail),
        .hb_seen_o         (hb_seen),
        .first_fail_idx_o  (ff_idx),
        .first_fail_code_o (ff_code)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [NumCh-1:0] en);
        ch_en = en;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [NumCh*4+CodeW+7:0] obs;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        obs = {state, done, pass, timeout, seen, fail, hb_seen, ff_idx, ff_code, ready};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", obs);
        end
    endtask

    task automatic test_in_order();
        int ord[4] = '{2, 0, 3, 1};
        arm(4'hF);
        checks++;
        if (state !== 2'd1 || ready !== 4'hF) begin
            failures++;
            $display("FAIL arm_state got state=%0d ready=%b exp state=1 ready=1111", state, ready);
        end
        code = '0;
        for (int k = 0; k < 3; k++) begin
            valid = 4'b1 << ord[k];
            tick();
        end
        valid = '0;
        checks++;
        if (done !== 1'b0 || seen !== 4'b1101) begin
            failures++;
            $display("FAIL in_order_partial got done=%b seen=%b exp done=0 seen=1101", done, seen);
        end
        valid = 4'b0010;
        tick();
        valid = '0;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || fail !== 4'b0000 || seen !== 4'hF || state !== 2'd2) begin
            failures++;
            $display("FAIL in_order_done got done=%b pass=%b fail=%b seen=%b state=%0d exp 1 1 0000 1111 2",
                     done, pass, fail, seen, state);
        end
    endtask

    task automatic test_first_fail();
        arm(4'hF);
        code = '0;
        code[1*CodeW +: CodeW] = 31'h5;
        code[3*CodeW +: CodeW] = 31'h7;
        valid = 4'b1010;
        tick();
        valid = '0;
        code = '0;
        checks++;
        if (ff_idx !== 2'd1 || ff_code !== 31'h5 || fail !== 4'b1010 || done !== 1'b0) begin
            failures++;
            $display("FAIL first_fail_capture got idx=%0d code=%h fail=%b done=%b exp 1 5 1010 0",
                     ff_idx, ff_code, fail, done);
        end
        valid = 4'b0001;
        tick();
        valid = 4'b0100;
        tick();
        valid = '0;
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || ff_idx !== 2'd1 || ff_code !== 31'h5 || fail !== 4'b1010) begin
            failures++;
            $display("FAIL first_fail_done got done=%b pass=%b idx=%0d code=%h fail=%b exp 1 0 1 5 1010",
                     done, pass, ff_idx, ff_code, fail);
        end
    endtask

    task automatic test_timeout();
        arm(4'b0011);
        code = '0;
        valid = 4'b0001;
        tick();
        valid = '0;
        for (int i = 0; i < 98; i++) tick();
        checks++;
        if (state !== 2'd1 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got state=%0d timeout=%b exp state=1 timeout=0", state, timeout);
        end
        tick();
        checks++;
        if (state !== 2'd3 || timeout !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || seen !== 4'b1101 ||
            ready !== 4'b0000) begin
            failures++;
            $display("FAIL timeout_expire got state=%0d to=%b done=%b pass=%b seen=%b ready=%b exp 3 1 0 0 1101 0000",
                     state, timeout, done, pass, seen, ready);
        end
    endtask

    task automatic test_expiry_done();
        arm(4'hF);
        code = '0;
        valid = 4'b0111;
        tick();
        valid = '0;
        for (int i = 0; i < 98; i++) tick();
        valid = 4'b1000;
        tick();
        valid = '0;
        checks++;
        if (state !== 2'd2 || timeout !== 1'b0 || done !== 1'b1 || pass !== 1'b1) begin
            failures++;
            $display("FAIL expiry_tie got state=%0d timeout=%b done=%b pass=%b exp 2 0 1 1",
                     state, timeout, done, pass);
        end
        valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ready !== 4'b0000 || state !== 2'd2) begin
                failures++;
                $display("FAIL done_no_ready got ready=%b state=%0d exp 0000 2", ready, state);
            end
        end
        valid = '0;
    endtask

    task automatic test_heartbeat();
        heartbeat = 4'b0100;
        arm(4'hF);
        tick();
        tick();
        checks++;
        if (hb_seen !== 4'b0000) begin
            failures++;
            $display("FAIL hb_preheld got=%b exp=0000", hb_seen);
        end
        heartbeat = 4'b0000;
        tick();
        heartbeat = 4'b0100;
        tick();
        heartbeat = 4'b0000;
        checks++;
        if (hb_seen !== 4'b0100) begin
            failures++;
            $display("FAIL hb_edge got=%b exp=0100", hb_seen);
        end
    endtask

    task automatic test_rearm_clears();
        code = '0;
        code[0 +: CodeW] = 31'h3;
        valid = 4'hF;
        tick();
        checks++;
        if (done !== 1'b1 || fail !== 4'b0001 || ff_idx !== 2'd0 || ff_code !== 31'h3) begin
            failures++;
            $display("FAIL rearm_pre got done=%b fail=%b idx=%0d code=%h exp 1 0001 0 3", done, fail, ff_idx, ff_code);
        end
        arm(4'hF);
        valid = '0;
        code = '0;
        checks++;
        if (seen !== 4'h0 || fail !== 4'h0 || hb_seen !== 4'h0 || ff_code !== '0 || state !== 2'd1 ||
            ready !== 4'hF) begin
            failures++;
            $display("FAIL rearm_clear got seen=%b fail=%b hb=%b code=%h state=%0d ready=%b exp 0 0 0 0 1 1111",
                     seen, fail, hb_seen, ff_code, state, ready);
        end
    endtask

    task automatic test_start_priority();
        code[0 +: CodeW] = 31'h9;
        valid = 4'b0001;
        arm(4'hF);
        valid = '0;
        code = '0;
        checks++;
        if (seen !== 4'h0 || fail !== 4'h0 || ff_code !== '0) begin
            failures++;
            $display("FAIL start_priority got seen=%b fail=%b code=%h exp 0000 0000 0", seen, fail, ff_code);
        end
    endtask

    task automatic test_reset_midrun();
        logic [NumCh*4+CodeW+7:0] obs;
        code[1*CodeW +: CodeW] = 31'h4;
        valid = 4'b0010;
        heartbeat = 4'b0001;
        tick();
        valid = '0;
        checks++;
        if (seen !== 4'b0010 || fail !== 4'b0010 || hb_seen !== 4'b0001) begin
            failures++;
            $display("FAIL midrun_pre got seen=%b fail=%b hb=%b exp 0010 0010 0001", seen, fail, hb_seen);
        end
        rst = 1'b1;
        valid = 4'b0100;
        tick();
        rst = 1'b0;
        valid = '0;
        heartbeat = '0;
        code = '0;
        obs = {state, done, pass, timeout, seen, fail, hb_seen, ff_idx, ff_code, ready};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL midrun_reset got=%h exp=0", obs);
        end
    endtask

    task automatic test_all_disabled();
        arm(4'h0);
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL all_dis_armed got state=%0d exp=1", state);
        end
        tick();
        checks++;
        if (state !== 2'd2 || pass !== 1'b1 || seen !== 4'hF) begin
            failures++;
            $display("FAIL all_dis_done got state=%0d pass=%b seen=%b exp 2 1 1111", state, pass, seen);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_first_fail();
        test_timeout();
        test_expiry_done();
        test_heartbeat();
        test_rearm_clears();
        test_start_priority();
        test_reset_midrun();
        test_all_disabled();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rt_eoc_monitor.md
Name: rt_eoc_monitor

Overview:
- Synthesizable, parametrised end-of-computation collector and watchdog for multi-hart RT subsystem bring-up.
- Replaces single-channel polled exit-code and GPIO-blink checks with N channels, each handing over a 31-bit exit code through a valid/ready handshake.
- Watches per-channel heartbeat pins and enforces a cycle timeout.
- Aggregated pass/fail/timeout status is exposed for the debug module and status GPIOs.

Parameters:
- NumCh, 4, number of monitored channels (harts), 1..32.
- CodeW, 31, exit-code width; code 0 = success.
- TimeoutCycles, 1000000, watchdog limit in clk_i cycles; 0 disables the watchdog.
- CntW, $clog2(TimeoutCycles+1) (minimum 1), watchdog counter width (derived, not overridden).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  arm/re-arm pulse
- ch_en_i  in  NumCh  channel enable; sampled on start_i
- eoc_valid_i  in  NumCh  exit code valid per channel
- eoc_code_i  in  NumCh*CodeW  packed exit codes; channel c at [c*CodeW +: CodeW]
- eoc_ready_o  out  NumCh  handshake ready per channel
- heartbeat_i  in  NumCh  activity pins (e.g. GPIO)
- state_o  out  2  0=IDLE, 1=ARMED, 2=DONE, 3=TIMEOUT
- done_o  out  1  all enabled channels reported
- pass_o  out  1  done_o and no failures
- timeout_o  out  1  watchdog expired
- seen_mask_o  out  NumCh  channels that reported (disabled channels read 1)
- fail_mask_o  out  NumCh  channels that reported a nonzero code
- hb_seen_o  out  NumCh  heartbeat rising edge observed while ARMED
- first_fail_idx_o  out  $clog2(NumCh) (min 1)  index of the first failing channel
- first_fail_code_o  out  CodeW  code of the first failing channel

Behaviour:
- Reset: state IDLE, all outputs 0, counter 0, en_q 0, hb_prev_q 0.
- IDLE: eoc_ready_o=0. start_i -> ARMED next cycle.
- Arming (start_i in any state, including ARMED, DONE, TIMEOUT):
  - en_q<=ch_en_i; seen<=~ch_en_i; fail, hb_seen, first_fail_* <=0; counter<=0.
  - hb_prev_q<=heartbeat_i, so an already-high pin does not count as an edge.
  - start_i has priority over any same-cycle handshake or timeout.
- ARMED:
  - eoc_ready_o[c]=~seen[c] (combinational from registered state).
  - Handshake on channel c = valid & ready: seen[c]<=1; fail[c]<=(code!=0).
  - Duplicate valid after acceptance is never accepted (ready low); no error is flagged.
  - First-fail capture: if none captured yet, latch the lowest-index failing channel among this cycle's handshakes. Later failures do not overwrite it.
  - Heartbeat: hb_seen[c]<=1 on heartbeat_i[c]&~hb_prev_q[c]. hb_prev_q is updated every cycle.
  - Counter increments each cycle while ARMED, saturating at TimeoutCycles.
  - Transition to DONE when seen, including this cycle's accepts, is all ones. done_o asserts the cycle after the final handshake.
  - Transition to TIMEOUT when TimeoutCycles!=0, counter==TimeoutCycles-1, and DONE is not reached that cycle. Simultaneous final handshake and expiry -> DONE wins.
  - All channels disabled at arm: DONE one cycle after ARMED is entered, pass_o=1.
- DONE: done_o=1; pass_o=~|fail; eoc_ready_o=0; masks frozen. Sticky until start_i or rst_i.
- TIMEOUT: timeout_o=1; done_o=0; pass_o=0; masks frozen, showing which channels are missing. Sticky until start_i or rst_i.
- rst_i mid-operation: immediate return to reset values on the next edge; any in-flight handshake is discarded.
- Enable changes: ch_en_i changes while ARMED are ignored.

Decomposition:
- rt_pkg gains eoc_state_e (IDLE/ARMED/DONE/TIMEOUT, 2-bit), EocCodeW=31, and the default timeout constant.
- Sub-module rt_eoc_channel (one per channel, generate loop) holds seen/fail/hb_seen/hb_prev and its handshake.
- Top level holds the FSM, watchdog counter, and first-fail priority encoder.

Test Plan:
- NumCh=4, all enabled. Codes 0 on ch2, ch0, ch3, ch1 in separate cycles -> done_o=1 one cycle after the ch1 handshake, pass_o=1, fail_mask_o=4'b0000, seen_mask_o=4'hF.
- ch1 code 0x5 and ch3 code 0x7 in the same cycle, then ch0 and ch2 code 0 -> first_fail_idx_o=1, first_fail_code_o=0x5, fail_mask_o=4'b1010, pass_o=0.
- TimeoutCycles=100, ch_en_i=4'b0011, only ch0 reports -> timeout_o=1 with state_o=3 on cycle 100 after arm, seen_mask_o=4'b1101.
- Final handshake on the exact expiry cycle -> state_o=2, timeout_o=0. Then hold ch0 valid in DONE -> eoc_ready_o stays 0.
- heartbeat_i[2] held high before arm, then toggled 0->1 -> hb_seen_o[2] set only after the toggle. start_i in DONE clears all masks. rst_i mid-run returns every output to 0.
